// File: rtl/shape_pkg.sv
// Shared types, field positions and legality rules for the shape command sequencer.
// Used by shape_cmd_sequencer (optional readback stage: SHAPE_CMD_READBACK_EN).
package shape_pkg;

    typedef logic [1:0] shape_t;
    typedef logic [4:0] operation_t;

    typedef enum logic [1:0] {
        OK       = 2'b00,
        ILLEGAL  = 2'b01,
        MISMATCH = 2'b10,
        ERROR    = 2'b11
    } status_t;

    localparam int SHAPE_LSB = 16;
    localparam int OP_LSB    = 0;

    function automatic logic is_legal_shape(shape_t s);
        return (s == 2'b01) || (s == 2'b10);
    endfunction

    function automatic logic is_legal_operation(operation_t op);
        case (op[4:3])
            2'b00:   return op[2:0] <= 3'd1;
            2'b01:   return op[2:0] == 3'd0;
            2'b10:   return op[2:0] <= 3'd1;
            default: return 1'b0;
        endcase
    endfunction

    // Class-specific operations must target the shape named by their class bits.
    function automatic logic is_legal_combination(shape_t s, operation_t op);
        return (op[4:3] == 2'b00) || (op[4:3] == s);
    endfunction

    function automatic logic [31:0] pack_cmd(shape_t s, operation_t op);
        logic [31:0] w;
        w = '0;
        w[SHAPE_LSB +: 2] = s;
        w[OP_LSB +: 5]    = op;
        return w;
    endfunction

endpackage

// File: rtl/shape_rr_arbiter.sv
// Round-robin grant among NUM_REQ requesters; the pointer holds the last granted
// index and moves only when the owner accepts a grant via advance.
module shape_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] last;

    // Walk from the farthest candidate to the nearest so the nearest one after
    // the pointer overrides any earlier hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NUM_REQ]) begin
                grant = '0;
                grant[(int'(last) + k) % NUM_REQ] = 1'b1;
                grant_idx = IDX_W'((int'(last) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= IDX_W'(NUM_REQ - 1);
        end else if (advance && (|req)) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/shape_cmd_sequencer.sv
// Arbitrates shape commands onto a single processor register port.
// Define SHAPE_CMD_READBACK_EN to add the read-back/compare (READ, CHECK) stage.
module shape_cmd_sequencer
    import shape_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   req_shape,
    input  logic [5*NUM_REQ-1:0]   req_op,
    output logic [NUM_REQ-1:0]     done,
    output logic [1:0]             status,
    output logic                   busy,
    output logic                   write,
    output logic [31:0]            write_data,
    output logic                   read,
    input  logic [31:0]            read_data,
    input  logic                   error
);

    localparam int IDX_W = $clog2(NUM_REQ);

`ifdef SHAPE_CMD_READBACK_EN
    typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, WRITE, RESP} state_t;
`endif

    state_t           state;
    status_t          status_q;
    logic [IDX_W-1:0] idx;
    shape_t           shape_q;
    operation_t       op_q;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] idx_oh;
    shape_t             shapes [NUM_REQ];
    operation_t         ops    [NUM_REQ];
    shape_t             sel_shape;
    operation_t         sel_op;
    logic               sel_legal;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign shapes[g] = req_shape[2*g +: 2];
        assign ops[g]    = req_op[5*g +: 5];
    end

    shape_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .advance   (state == IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Legality is decided on the granted fields, which are exactly what gets latched.
    assign sel_shape = shapes[grant_idx];
    assign sel_op    = ops[grant_idx];
    assign sel_legal = is_legal_shape(sel_shape) && is_legal_operation(sel_op) &&
                       is_legal_combination(sel_shape, sel_op);

    always_comb begin
        idx_oh      = '0;
        idx_oh[idx] = 1'b1;
    end

    assign busy   = (state != IDLE);
    assign status = status_q;

`ifdef SHAPE_CMD_READBACK_EN
    logic err_q;
    logic rd_match;

    assign rd_match = (read_data[SHAPE_LSB +: 2] == shape_q) &&
                      (read_data[OP_LSB +: 5] == op_q);
`else
    logic unused_readback;
    assign unused_readback = ^{read_data, shape_q, op_q};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            status_q   <= OK;
            idx        <= '0;
            shape_q    <= '0;
            op_q       <= '0;
            done       <= '0;
            write      <= 1'b0;
            write_data <= '0;
            read       <= 1'b0;
`ifdef SHAPE_CMD_READBACK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            done       <= '0;
            status_q   <= OK;
            write      <= 1'b0;
            write_data <= '0;
            read       <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        idx     <= grant_idx;
                        shape_q <= sel_shape;
                        op_q    <= sel_op;
`ifdef SHAPE_CMD_READBACK_EN
                        err_q   <= 1'b0;
`endif
                        if (sel_legal) begin
                            state      <= WRITE;
                            write      <= 1'b1;
                            write_data <= pack_cmd(sel_shape, sel_op);
                        end else begin
                            state    <= RESP;
                            done     <= grant;
                            status_q <= ILLEGAL;
                        end
                    end
                end
`ifdef SHAPE_CMD_READBACK_EN
                WRITE: begin
                    state <= READ;
                    read  <= 1'b1;
                    err_q <= error;
                end
                READ: begin
                    state <= CHECK;
                    err_q <= err_q | error;
                end
                CHECK: begin
                    state    <= RESP;
                    done     <= idx_oh;
                    status_q <= (err_q || error) ? ERROR : (rd_match ? OK : MISMATCH);
                end
`else
                WRITE: begin
                    state    <= RESP;
                    done     <= idx_oh;
                    status_q <= error ? ERROR : OK;
                end
`endif
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shape_cmd_sequencer.sv
// Randomized bench for shape_cmd_sequencer against a transaction-level model
// (round-robin winner, legality table, expected latency and completion code).
module tb_shape_cmd_sequencer;

    localparam int NR = 4;
`ifdef SHAPE_CMD_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic [NR-1:0]       req;
    logic [2*NR-1:0]     req_shape;
    logic [5*NR-1:0]     req_op;
    logic [NR-1:0]       done;
    logic [1:0]          status;
    logic                busy;
    logic                write;
    logic [31:0]         write_data;
    logic                read;
    logic [31:0]         read_data;
    logic                error;

    int total = 0;
    int bad   = 0;
    int last_g = NR - 1;

    shape_cmd_sequencer #(.NUM_REQ(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_shape  (req_shape),
        .req_op     (req_op),
        .done       (done),
        .status     (status),
        .busy       (busy),
        .write      (write),
        .write_data (write_data),
        .read       (read),
        .read_data  (read_data),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit legal_cmd(input logic [1:0] s, input logic [4:0] o);
        bit op_ok;
        op_ok = (o == 5'b00000) || (o == 5'b00001) || (o == 5'b01000) ||
                (o == 5'b10000) || (o == 5'b10001);
        return (s == 2'b01 || s == 2'b10) && op_ok && (o[4:3] == 2'b00 || o[4:3] == s);
    endfunction

    // One command from grant to the IDLE cycle after done. Caller sits on a negedge
    // with the DUT idle; err_c is the cycle (1 = first after grant) error is raised.
    task automatic txn(input logic [NR-1:0] r, input logic [2*NR-1:0] shv,
                       input logic [5*NR-1:0] opv, input int err_c,
                       input logic [31:0] rx, input bit hold);
        int w, done_c, expst;
        bit legal, erred;
        logic [1:0] s;
        logic [4:0] o;
        logic [31:0] wd, rnd;
        logic [NR-1:0] oh;
        logic [NR+4:0] ev, av;

        req = r; req_shape = shv; req_op = opv; error = 1'b0;
        w = -1;
        for (int k = 1; k <= NR; k++)
            if (w < 0 && r[(last_g + k) % NR]) w = (last_g + k) % NR;
        if (w < 0) w = 0;
        last_g = w;
        s = shv[2*w +: 2];
        o = opv[5*w +: 5];
        legal  = legal_cmd(s, o);
        wd     = {14'b0, s, 11'b0, o};
        done_c = !legal ? 1 : (RB ? 4 : 2);
        erred  = legal && err_c >= 1 && err_c <= (RB ? 3 : 1);
        expst  = !legal ? 1 : erred ? 3 : (RB && (rx & 32'h0003_001F) != 0) ? 2 : 0;
        oh = '0;
        oh[w] = 1'b1;

        @(posedge clk);
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clk);
            rnd = $urandom;
            req_shape = rnd[2*NR-1:0];
            rnd = $urandom;
            req_op = rnd[5*NR-1:0];
            if (!hold) req = '0;
            error = (c == err_c);
            read_data = (c == 3) ? (wd ^ rx) : $urandom;
            ev = {legal && c == 1, RB && legal && c == 2,
                  (c == done_c) ? oh : {NR{1'b0}},
                  (c == done_c) ? 2'(expst) : 2'b00, c <= done_c};
            av = {write, read, done, status, busy};
            chk($sformatf("cyc%0d_req%0d", c, w), 64'(av), 64'(ev));
            if (legal && c == 1) chk("wdata", 64'(write_data), 64'(wd));
        end
        error = 1'b0;
    endtask

    task automatic reset_mid();
        req = 1; req_shape = 8'b0000_0001; req_op = 20'b01000; error = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_write", 64'(write), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", 64'({write, read, done, status, busy, write_data}), 64'd0);
        req = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_nodone", 64'({done, busy}), 64'd0);
        end
        rst_n = 1'b1;
        last_g = NR - 1;
    endtask

    initial begin
        logic [2*NR-1:0] shv;
        logic [5*NR-1:0] opv;
        logic [NR-1:0] r;
        logic [31:0] rx;
        logic [4:0] o;
        int pick;

        rst_n = 1'b0; req = '0; req_shape = '0; req_op = '0;
        read_data = '0; error = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out", 64'({write, read, done, status, busy, write_data}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        txn(4'b0001, 8'b0000_0001, 20'b01000, 0, 32'h0, 1'b0);          // legal, echo
        txn(4'b0010, 8'b0000_1000, {10'b0, 5'b01000, 5'b0}, 0, 32'h0, 1'b0); // illegal combo
        txn(4'b0001, 8'b0000_0001, 20'b00001, 0, 32'h0003_0000, 1'b0);  // readback mismatch
        txn(4'b0001, 8'b0000_0001, 20'b00001, 2, 32'h0, 1'b0);          // error in READ
        txn(4'b0001, 8'b0000_0010, 20'b00001, 1, 32'h0003_0000, 1'b0);  // error beats mismatch
        txn(4'b0001, 8'b0000_0010, 20'b10001, 0, 32'h0100_8000, 1'b0);  // non-field bits ignored
        reset_mid();
        for (int i = 0; i < 4; i++)
            txn(4'b0011, 8'b0000_1001, {10'b0, 5'b10001, 5'b00000}, 0, 32'h0, 1'b1);

        for (int n = 0; n < 250; n++) begin
            r = NR'($urandom);
            if (r == '0) r[$urandom_range(0, NR-1)] = 1'b1;
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    pick = $urandom_range(0, 4);
                    o = (pick == 0) ? 5'b00000 : (pick == 1) ? 5'b00001 :
                        (pick == 2) ? 5'b01000 : (pick == 3) ? 5'b10000 : 5'b10001;
                    opv[5*i +: 5] = o;
                    shv[2*i +: 2] = (o[4:3] != 2'b00) ? o[4:3] :
                                    ($urandom_range(0, 1) != 0 ? 2'b01 : 2'b10);
                end else begin
                    opv[5*i +: 5] = 5'($urandom);
                    shv[2*i +: 2] = 2'($urandom);
                end
            end
            pick = $urandom_range(0, 2);
            if (pick == 0) rx = 32'h0;
            else if (pick == 1) begin
                pick = $urandom_range(0, 6);
                rx = (pick < 5) ? (32'h1 << pick) : (32'h1 << (pick + 11));
            end else begin
                pick = $urandom_range(0, 24);
                rx = (pick < 11) ? (32'h1 << (pick + 5)) : (32'h1 << (pick + 7));
            end
            txn(r, shv, opv, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0,
                rx, $urandom_range(0, 1) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shape_cmd_sequencer.md
SHAPE_CMD_SEQUENCER -- requirements
Module: shape_cmd_sequencer

Interface
REQ-001 SHALL have parameter: NUM_REQ, 2, number of requesters sharing the shape processor (2..8).
REQ-002 SHALL have ports, one clock; reset is asynchronous and active-low:
  clk  in  1  single clock, all logic on rising edge
  rst_n  in  1  asynchronous active-low reset
  req  in  NUM_REQ  per-requester command request, level, held until done
  req_shape  in  2*NUM_REQ  per-requester shape field, slice i = [2i+1:2i]
  req_op  in  5*NUM_REQ  per-requester operation field, slice i = [5i+4:5i]
  done  out  NUM_REQ  one-cycle completion pulse to the served requester
  status  out  2  completion code, valid while any done bit high
  busy  out  1  high whenever FSM not in IDLE
  write  out  1  processor register write strobe
  write_data  out  32  processor write data
  read  out  1  processor register read strobe
  read_data  in  32  processor read data, valid the cycle after read
  error  in  1  processor error flag

Function
REQ-003 SHALL implement FSM states IDLE, WRITE, READ, CHECK, RESP.
REQ-004 In IDLE with any req bit high, SHALL grant one requester round-robin: search starts at index after last granted, wraps at NUM_REQ-1 to 0.
REQ-005 On grant SHALL latch requester index, shape and operation; later changes of req_* inputs SHALL have no effect on the command in flight.
REQ-006 Legality SHALL be checked on latched values: shape one-hot; op[4:3]=00 needs op[2:0] in {0,1}; 01 needs op[2:0]=0; 10 needs op[2:0] in {0,1}; 11 illegal; if op[4:3]!=00 then op[4:3] SHALL equal shape.
REQ-007 Illegal command: IDLE -> RESP next cycle, no write/read strobe, status=01 (ILLEGAL).
REQ-008 Legal command: IDLE -> WRITE; in WRITE write=1 for exactly one cycle, write_data[17:16]=shape, [4:0]=op, all other bits 0.
REQ-009 WRITE -> READ; read=1 for exactly one cycle; READ -> CHECK.
REQ-010 In CHECK SHALL compare read_data[17:16] and [4:0] with latched values; match -> status=00 (OK), mismatch -> 10 (MISMATCH).
REQ-011 error sampled high in any of WRITE, READ, CHECK SHALL force status=11 (ERROR), overriding MISMATCH/OK.
REQ-012 In RESP done[idx]=1 for one cycle with status; RESP -> IDLE unconditionally.
REQ-013 Latency from req sampled in IDLE (cycle N): legal -> done at N+4; illegal -> done at N+1.
REQ-014 At most one done bit high per cycle; write and read never high together; no new grant before return to IDLE.
REQ-015 req dropped mid-command: command SHALL complete and done still pulse.
REQ-016 status SHALL be 00 and done 0 whenever no done bit is asserted.
REQ-017 Round-robin pointer SHALL update only on grant; illegal commands count as grants.

Reset
REQ-018 rst_n low SHALL immediately force IDLE, done=0, status=00, busy=0, write=0, write_data=0, read=0.
REQ-019 Round-robin pointer SHALL reset so requester 0 has highest priority.
REQ-020 Reset mid-command SHALL abandon it with no done pulse; requester re-requests after reset.

Configuration
REQ-021 Macro SHAPE_CMD_READBACK_EN defined: READ and CHECK states present, behaviour per REQ-009/010.
REQ-022 Macro undefined: WRITE -> RESP directly, no read strobe, read_data ignored, legal done at N+2, status 00 or 11 (error in WRITE).

Structure
REQ-023 Package shape_pkg SHALL hold shape_t (2b), operation_t (5b), status_t enum (OK, ILLEGAL, MISMATCH, ERROR), field position constants (SHAPE_LSB=16, OP_LSB=0) and legality functions is_legal_shape/is_legal_operation/is_legal_combination.
REQ-024 Round-robin grant SHALL be sub-module shape_rr_arbiter (req, advance, grant one-hot, pointer state).

Verification
REQ-025 Req0 shape=01 op=01000 -> write_data=0x0001_0008 at N+1, read at N+2, model returns same, done[0] at N+4 with status 00.
REQ-026 Req1 shape=10 op=01000 -> no write, done[1] at N+1 with status 01.
REQ-027 req=11 held, all legal -> grants alternate 0,1,0,1; after reset first grant is 0.
REQ-028 Model returns read_data=0x0002_0001 for written 0x0001_0001 -> status 10.
REQ-029 error pulsed during READ -> status 11; rst_n low in WRITE -> outputs zero at once, no done.
REQ-030 Build without SHAPE_CMD_READBACK_EN: legal req -> done at N+2, read never asserted.
